// File: rtl/ultrasonic_pkg.sv
// Shared types for the ultrasonic ranger: FSM states, status codes
// and a small helper for sizing counters.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      PUBLISH,
      HOLDOFF
   } state_t;

   localparam logic [1:0] ST_OK        = 2'b00;
   localparam logic [1:0] ST_NO_ECHO   = 2'b01;
   localparam logic [1:0] ST_OVERRANGE = 2'b10;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond strobe: one-clk pulse every DIV clocks, restarted by clr
// so the first pulse after clr lands exactly DIV clocks later.
module us_tick_gen #(
   parameter int DIV = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class range controller: trigger, echo timing in us ticks,
// running divide to centimetres, timeouts, continuous mode, holdoff.
module ultrasonic_ranger
   import ultrasonic_pkg::*;
#(
   parameter int CLK_HZ          = 100_000_000,
   parameter int TRIG_US         = 10,
   parameter int RISE_TIMEOUT_US = 1000,
   parameter int ECHO_TIMEOUT_US = 25000,
   parameter int HOLDOFF_US      = 60000,
   parameter int CM_DIV          = 58,
   parameter int DIST_W          = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cont_en,
   input  logic              echo,
   output logic              trig,
   output logic [DIST_W-1:0] distance,
   output logic [1:0]        status,
   output logic              valid,
   output logic              busy
);

   localparam int TICK_DIV = CLK_HZ / 1_000_000;
   localparam int UMAX = imax(imax(TRIG_US, RISE_TIMEOUT_US),
                              imax(ECHO_TIMEOUT_US, HOLDOFF_US));
   localparam int UW = $clog2(UMAX + 1);
   localparam int SW = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;
   localparam logic [DIST_W-1:0] DMAX = '1;

   state_t state_q, state_d;
   logic [UW-1:0]     us_q, us_d, us_inc;
   logic [SW-1:0]     sub_q, sub_d;
   logic [DIST_W-1:0] cm_q, cm_d;
   logic [DIST_W-1:0] dist_q, dist_d;
   logic [1:0]        stat_q, stat_d;
   logic              pend_q, pend_d;
   logic              trig_q, trig_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              echo_m_q, echo_s_q;
   logic              tick, clr;

   assign clr = (state_d != state_q);

   us_tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      us_d    = us_q;
      sub_d   = sub_q;
      cm_d    = cm_q;
      pend_d  = pend_q;
      dist_d  = dist_q;
      stat_d  = stat_q;
      us_inc  = us_q + UW'(1);
      if (start && state_q != IDLE) pend_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (start || cont_en) state_d = TRIG;
         end
         TRIG: begin
            if (tick) begin
               us_d = us_inc;
               if (us_inc == UW'(TRIG_US)) state_d = WAIT_RISE;
            end
         end
         WAIT_RISE: begin
            if (echo_s_q) begin
               state_d = MEASURE;
            end else if (tick) begin
               us_d = us_inc;
               if (us_inc == UW'(RISE_TIMEOUT_US)) begin
                  state_d = PUBLISH;
                  dist_d  = '0;
                  stat_d  = ST_NO_ECHO;
               end
            end
         end
         MEASURE: begin
            // the tick on the exit edge still covers a us of high echo
            if (tick) begin
               us_d = us_inc;
               if (sub_q == SW'(CM_DIV - 1)) begin
                  sub_d = '0;
                  if (cm_q != DMAX) cm_d = cm_q + DIST_W'(1);
               end else begin
                  sub_d = sub_q + SW'(1);
               end
            end
            if (tick && us_inc == UW'(ECHO_TIMEOUT_US)) begin
               state_d = PUBLISH;
               dist_d  = DMAX;
               stat_d  = ST_OVERRANGE;
            end else if (!echo_s_q) begin
               state_d = PUBLISH;
               dist_d  = cm_d;
               stat_d  = ST_OK;
            end
         end
         PUBLISH: begin
            state_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (tick) begin
               us_d = us_inc;
               if (us_inc == UW'(HOLDOFF_US))
                  state_d = (pend_q || start || cont_en) ? TRIG : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         us_d  = '0;
         sub_d = '0;
         cm_d  = '0;
         if (state_d == TRIG || state_d == IDLE) pend_d = 1'b0;
      end
      trig_d  = (state_d == TRIG);
      valid_d = (state_d == PUBLISH);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         us_q     <= '0;
         sub_q    <= '0;
         cm_q     <= '0;
         dist_q   <= '0;
         stat_q   <= ST_OK;
         pend_q   <= 1'b0;
         trig_q   <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         echo_m_q <= 1'b0;
         echo_s_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         us_q     <= us_d;
         sub_q    <= sub_d;
         cm_q     <= cm_d;
         dist_q   <= dist_d;
         stat_q   <= stat_d;
         pend_q   <= pend_d;
         trig_q   <= trig_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         echo_m_q <= echo;
         echo_s_q <= echo_m_q;
      end
   end

   assign trig     = trig_q;
   assign distance = dist_q;
   assign status   = stat_q;
   assign valid    = valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: three configurations share one stimulus
// stream and are checked each cycle against a timeline-based model.
module tb_ultrasonic_ranger;

   localparam int D    = 10;
   localparam int TRUS = 10;
   localparam int RTO  = 50;
   localparam int HOLD = 100;
   localparam int CM   = 58;
   localparam int LIM  = 30000;
   localparam int ETO  [3] = '{600, 2000, 2000};
   localparam int DMAX [3] = '{511, 511, 7};

   localparam int P_IDLE = 0;
   localparam int P_TRIG = 1;
   localparam int P_WAIT = 2;
   localparam int P_MEAS = 3;
   localparam int P_PUB  = 4;
   localparam int P_HOLD = 5;

   logic clk = 0;
   logic reset, start, cont_en, echo;
   logic       trig_o  [3];
   logic       busy_o  [3];
   logic       valid_o [3];
   logic [8:0] dist_o  [3];
   logic [1:0] stat_o  [3];
   logic [8:0] dist_a, dist_b;
   logic [2:0] dist_c;

   int checks = 0;
   int failures = 0;
   int nprint = 0;
   int cyc_n = 0;
   bit chk_en = 0;
   int vcnt [3] = '{0, 0, 0};

   int         m_ph   [3];
   int         m_n    [3];
   bit         m_pend [3];
   logic [8:0] m_dist [3];
   logic [1:0] m_stat [3];
   logic       es1, es2;

   always #5 clk = ~clk;

   ultrasonic_ranger #(
      .CLK_HZ(10_000_000), .TRIG_US(TRUS), .RISE_TIMEOUT_US(RTO),
      .ECHO_TIMEOUT_US(600), .HOLDOFF_US(HOLD), .CM_DIV(CM), .DIST_W(9)
   ) u_a (
      .clk(clk), .reset(reset), .start(start), .cont_en(cont_en),
      .echo(echo), .trig(trig_o[0]), .distance(dist_a),
      .status(stat_o[0]), .valid(valid_o[0]), .busy(busy_o[0])
   );

   ultrasonic_ranger #(
      .CLK_HZ(10_000_000), .TRIG_US(TRUS), .RISE_TIMEOUT_US(RTO),
      .ECHO_TIMEOUT_US(2000), .HOLDOFF_US(HOLD), .CM_DIV(CM), .DIST_W(9)
   ) u_b (
      .clk(clk), .reset(reset), .start(start), .cont_en(cont_en),
      .echo(echo), .trig(trig_o[1]), .distance(dist_b),
      .status(stat_o[1]), .valid(valid_o[1]), .busy(busy_o[1])
   );

   ultrasonic_ranger #(
      .CLK_HZ(10_000_000), .TRIG_US(TRUS), .RISE_TIMEOUT_US(RTO),
      .ECHO_TIMEOUT_US(2000), .HOLDOFF_US(HOLD), .CM_DIV(CM), .DIST_W(3)
   ) u_c (
      .clk(clk), .reset(reset), .start(start), .cont_en(cont_en),
      .echo(echo), .trig(trig_o[2]), .distance(dist_c),
      .status(stat_o[2]), .valid(valid_o[2]), .busy(busy_o[2])
   );

   assign dist_o[0] = dist_a;
   assign dist_o[1] = dist_b;
   assign dist_o[2] = {6'b0, dist_c};

   // Model: each phase is timed in clocks since entry; echo width in us
   // is floor(high clocks / D), distance is floor(us / CM) saturated.
   always @(posedge clk) begin
      int n, ph, nph, us;
      bit pend;
      logic [8:0] d;
      logic [1:0] s;
      cyc_n <= cyc_n + 1;
      es1 <= reset ? 1'b0 : echo;
      es2 <= reset ? 1'b0 : es1;
      for (int i = 0; i < 3; i++) begin
         n = m_n[i] + 1;
         ph = m_ph[i];
         nph = ph;
         pend = m_pend[i];
         d = m_dist[i];
         s = m_stat[i];
         if (start && ph != P_IDLE) pend = 1;
         case (ph)
            P_IDLE: if (start || cont_en) nph = P_TRIG;
            P_TRIG: if (n == TRUS * D) nph = P_WAIT;
            P_WAIT: begin
               if (es2) nph = P_MEAS;
               else if (n == RTO * D) begin
                  nph = P_PUB; d = 0; s = 2'd1;
               end
            end
            P_MEAS: begin
               us = n / D;
               if (us >= ETO[i]) begin
                  nph = P_PUB; d = 9'(DMAX[i]); s = 2'd2;
               end else if (!es2) begin
                  nph = P_PUB; s = 2'd0;
                  d = 9'((us / CM > DMAX[i]) ? DMAX[i] : us / CM);
               end
            end
            P_PUB: nph = P_HOLD;
            P_HOLD: if (n == HOLD * D) nph = (pend || cont_en) ? P_TRIG : P_IDLE;
            default: nph = P_IDLE;
         endcase
         if (nph != ph) begin
            n = 0;
            if (nph == P_TRIG || nph == P_IDLE) pend = 0;
         end
         if (reset) begin
            nph = P_IDLE; n = 0; pend = 0; d = 0; s = 0;
         end
         m_ph[i] <= nph;
         m_n[i] <= n;
         m_pend[i] <= pend;
         m_dist[i] <= d;
         m_stat[i] <= s;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            logic [13:0] got, exp;
            got = {trig_o[i], busy_o[i], valid_o[i], stat_o[i], dist_o[i]};
            exp = {m_ph[i] == P_TRIG, m_ph[i] != P_IDLE, m_ph[i] == P_PUB,
                   m_stat[i], m_dist[i]};
            checks++;
            if (got !== exp) begin
               failures++;
               if (nprint < 40) begin
                  nprint++;
                  $display("FAIL cycle%0d inst%0d {trig,busy,valid,st,dist}: got %h expected %h",
                           cyc_n, i, got, exp);
               end
            end
         end
      end
      for (int i = 0; i < 3; i++)
         if (valid_o[i] === 1'b1) vcnt[i] <= vcnt[i] + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1;
      cyc(1);
      start = 0;
   endtask

   task automatic wait_trig(input logic v, output int c);
      c = 0;
      while (trig_o[0] !== v && c < LIM) begin
         cyc(1);
         c++;
      end
      chk("wait_trig", int'(trig_o[0]), int'(v));
   endtask

   task automatic wait_valid0(output int c);
      c = 0;
      while (valid_o[0] !== 1'b1 && c < LIM) begin
         cyc(1);
         c++;
      end
      chk("wait_valid", int'(valid_o[0]), 1);
   endtask

   task automatic wait_idle();
      int c = 0;
      while ((busy_o[0] | busy_o[1] | busy_o[2]) !== 1'b0 && c < LIM) begin
         cyc(1);
         c++;
      end
      chk("idle", int'(busy_o[0] | busy_o[1] | busy_o[2]), 0);
   endtask

   task automatic echo_pulse(input int clks);
      echo = 1;
      cyc(clks);
      echo = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, w, v0, r1, dly, wid, a;
      bit idle_seen, ps;
      reset = 1; start = 0; cont_en = 0; echo = 0;
      cyc(3);
      chk_en = 1;
      chk("rst_trig", int'(trig_o[0]), 0);
      chk("rst_busy", int'(busy_o[0]), 0);
      chk("rst_dist", int'(dist_o[0]), 0);
      chk("rst_stat", int'(stat_o[0]), 0);
      reset = 0;
      cyc(2);

      // single shot, 1160 us echo
      v0 = vcnt[1];
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      chk("trig_width", w, 100);
      cyc(200);
      echo_pulse(11600);
      wait_idle();
      chk("s1_valid_once", vcnt[1] - v0, 1);
      chk("s1_b_dist", int'(dist_o[1]), 20);
      chk("s1_b_stat", int'(stat_o[1]), 0);
      chk("s1_model_b", int'(m_dist[1]), 20);
      chk("s1_a_dist", int'(dist_o[0]), 511);
      chk("s1_a_stat", int'(stat_o[0]), 2);
      chk("s1_c_sat", int'(dist_o[2]), 7);

      // no echo
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      wait_valid0(c);
      chk("s2_valid_delay", c, 500);
      chk("s2_dist", int'(dist_o[0]), 0);
      chk("s2_stat", int'(stat_o[0]), 1);
      wait_idle();

      // 700 us: overrange on A only
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      cyc(100);
      echo_pulse(7000);
      wait_idle();
      chk("s3_a_dist", int'(dist_o[0]), 511);
      chk("s3_a_stat", int'(stat_o[0]), 2);
      chk("s3_b_dist", int'(dist_o[1]), 12);
      chk("s3_c_dist", int'(dist_o[2]), 7);

      // 580 us: in range on A, saturated on C
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      cyc(100);
      echo_pulse(5800);
      wait_idle();
      chk("s3b_a_dist", int'(dist_o[0]), 10);
      chk("s3b_a_stat", int'(stat_o[0]), 0);
      chk("s3b_c_dist", int'(dist_o[2]), 7);
      chk("s3b_model_c", int'(m_dist[2]), 7);

      // continuous mode, two back-to-back measurements
      cont_en = 1;
      wait_trig(1, c);
      r1 = cyc_n;
      wait_trig(0, w);
      cyc(100);
      echo_pulse(1160);
      wait_valid0(c);
      chk("s4_dist1", int'(dist_o[0]), 2);
      idle_seen = 0;
      c = 0;
      while (trig_o[0] !== 1'b1 && c < LIM) begin
         if (busy_o[0] !== 1'b1) idle_seen = 1;
         cyc(1);
         c++;
      end
      chk("s4_retrig", int'(trig_o[0]), 1);
      chk("s4_no_idle", int'(idle_seen), 0);
      chk("s4_period_ge_hold", int'(cyc_n - r1 >= HOLD * D), 1);
      cont_en = 0;
      wait_trig(0, w);
      cyc(100);
      echo_pulse(2900);
      wait_valid0(c);
      chk("s4_dist2", int'(dist_o[0]), 5);
      wait_idle();

      // start during MEASURE and HOLDOFF queue one extra run
      v0 = vcnt[0];
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      cyc(100);
      echo = 1;
      cyc(1500);
      pulse_start();
      cyc(1499);
      echo = 0;
      wait_valid0(c);
      cyc(300);
      pulse_start();
      wait_idle();
      chk("s5_extra_one", vcnt[0] - v0, 2);
      chk("s5_stat", int'(stat_o[0]), 1);
      v0 = vcnt[0];
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      cyc(100);
      echo_pulse(1160);
      wait_idle();
      chk("s5_third", vcnt[0] - v0, 1);
      chk("s5_dist", int'(dist_o[0]), 2);

      // reset mid-TRIG
      pulse_start();
      wait_trig(1, c);
      cyc(30);
      reset = 1;
      cyc(1);
      chk("s6_trig", int'(trig_o[0]), 0);
      chk("s6_busy", int'(busy_o[0]), 0);
      chk("s6_dist", int'(dist_o[0]), 0);
      reset = 0;
      cyc(2);
      pulse_start();
      wait_trig(1, c);
      wait_trig(0, w);
      chk("s6_trig_width", w, 100);
      cyc(200);
      echo_pulse(1160);
      wait_idle();
      chk("s6_dist_after", int'(dist_o[1]), 2);

      // randomized single shots
      for (int it = 0; it < 6; it++) begin
         dly = $urandom_range(0, 700);
         wid = $urandom_range(2, 3000);
         ps = ($urandom_range(0, 2) == 0) && (dly <= 400);
         pulse_start();
         wait_trig(1, c);
         wait_trig(0, w);
         cyc(dly);
         a = wid / 2;
         echo = 1;
         cyc(a);
         if (ps) start = 1;
         cyc(1);
         start = 0;
         cyc(wid - a - 1);
         echo = 0;
         wait_idle();
      end

      cyc(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Parametrised HC-SR04-class range controller; successor to the single-shot distance block.
- Generates the trigger pulse and times the echo in 1 us ticks. Converts echo width to centimetres with a running divide, so no hardware divider is used.
- Adds a continuous-ranging mode, echo timeouts with status codes, a start-pending latch and a one-cycle result strobe.
- Sits between the echo/trig pins and the display/watch datapath.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; must be an integer multiple of 1_000_000.
- TRIG_US, 10, trigger high time in us.
- RISE_TIMEOUT_US, 1000, maximum wait from trig fall to echo rise.
- ECHO_TIMEOUT_US, 25000, maximum echo high time before overrange.
- HOLDOFF_US, 60000, minimum quiet time after each measurement.
- CM_DIV, 58, us of echo per cm.
- DIST_W, 9, distance width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request one measurement (level or pulse, sampled each clk)
- cont_en  in  1  continuous mode: re-trigger automatically after holdoff
- echo  in  1  asynchronous echo from sensor
- trig  out  1  trigger to sensor
- distance  out  DIST_W  last result in cm
- status  out  2  00 ok, 01 no_echo, 10 overrange
- valid  out  1  one-cycle strobe: distance/status updated
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, active-high, on posedge clk): state IDLE; trig=0, distance=0, status=00, valid=0, busy=0; pending=0; all counters 0. Reset mid-measurement aborts on the same edge.
- echo passes a 2-FF synchroniser (echo_s), adding 2 clk of latency; the design acts on echo_s only.
- us tick: TICK_DIV = CLK_HZ/1_000_000. Tick generator has a synchronous clr, asserted on every state change, so each state's first tick lands exactly TICK_DIV clk after entry.
- IDLE:
  - if start or cont_en, go to TRIG next edge.
- TRIG:
  - trig=1 for exactly TRIG_US*TICK_DIV clk; then trig=0 and go to WAIT_RISE.
  - pending cleared on entry.
- WAIT_RISE:
  - us counter counts ticks.
  - echo_s=1: go to MEASURE; us and cm counters cleared.
  - counter reaches RISE_TIMEOUT_US: go to PUBLISH with distance=0, status=01.
- MEASURE:
  - each tick while echo_s=1 increments us_sub. When us_sub hits CM_DIV-1 on a tick, it wraps to 0 and cm increments.
  - cm saturates at 2^DIST_W-1.
  - echo_s=0: go to PUBLISH, status=00.
  - total us reaches ECHO_TIMEOUT_US: go to PUBLISH, distance=2^DIST_W-1, status=10.
  - result = floor(echo_us/CM_DIV).
- PUBLISH (one cycle):
  - distance/status registered; valid=1 for this cycle only; go to HOLDOFF.
- HOLDOFF:
  - count HOLDOFF_US ticks (timed from PUBLISH exit), then:
    - pending or cont_en → TRIG (no IDLE cycle);
    - otherwise → IDLE.
- start while busy sets pending (at most one queued request). start in PUBLISH/HOLDOFF therefore yields exactly one further measurement.
- cont_en deasserted mid-measurement: current measurement completes; holdoff exit goes to IDLE unless pending.
- Echo already high on entering WAIT_RISE: measured immediately; the bench must not rely on this case.
- Echo glitch after fall, during HOLDOFF: ignored.
- distance holds its last value between valid strobes.

Decomposition:
- Shared package ultrasonic_pkg holds:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, PUBLISH, HOLDOFF);
  - status codes ST_OK/ST_NO_ECHO/ST_OVERRANGE.
- One sub-module: us_tick_gen (parameter DIV; ports clk, reset, clr, tick). tick is a one-clk pulse every DIV clk after clr.

Test Plan (CLK_HZ=10_000_000, HOLDOFF_US=100, RISE_TIMEOUT_US=50, ECHO_TIMEOUT_US=600, CM_DIV=58, DIST_W=9):
- start pulse; echo rises 20 us after trig fall, high 1160 us with ECHO_TIMEOUT_US=2000 → trig high exactly 100 clk; valid once; distance=20, status=00; busy low after holdoff.
- start; echo never rises → valid 50 us (+ sync latency) after trig fall; distance=0, status=01.
- start; echo held high 700 us → valid at 600 us; distance=511, status=10. With DIST_W=3 and echo 580 us (timeout raised): distance saturates at 7.
- cont_en=1, echo widths 116 then 290 us → two back-to-back measurements with no IDLE cycle; distances 2 then 5; trig period ≥ holdoff.
- start pulsed during MEASURE and again during HOLDOFF → exactly one extra measurement; a third start while IDLE runs another.
- reset asserted mid-TRIG → trig=0, busy=0, distance=0 on the next edge; a fresh start behaves as in the first scenario.
